// File: rtl/line_raster.sv
// Bresenham line rasteriser: latches two endpoints on `set`, then emits one pixel per clock.
// Optional clipping of off-screen pixels is enabled by defining LINE_RASTER_CLIP_EN.
module line_raster #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [X_WIDTH-1:0] x0,
    input  logic [Y_WIDTH-1:0] y0,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic               color_in,
    input  logic               set,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               color,
    output logic               pixel_valid,
    output logic               busy,
    output logic               done
);

    localparam int W  = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int EW = W + 2;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_DRAW, S_DONE} state_t;

    state_t state, state_next;

    logic [W-1:0] lx0, ly0, lx1, ly1;
    logic [W-1:0] major, minor, end_major, dx, dy;
    logic signed [EW-1:0] err;
    logic steep, ystep;

    // Setup arithmetic, evaluated from the latched endpoints while in S_INIT.
    logic [W-1:0] adx, ady;
    logic [W-1:0] p0_maj, p0_min, p1_maj, p1_min;
    logic [W-1:0] s_maj, s_min, e_maj, e_min;
    logic [W-1:0] dx_c, dy_c;
    logic         steep_c, swap_c;

    always_comb begin
        adx     = (lx1 >= lx0) ? lx1 - lx0 : lx0 - lx1;
        ady     = (ly1 >= ly0) ? ly1 - ly0 : ly0 - ly1;
        steep_c = ady > adx;
        p0_maj  = steep_c ? ly0 : lx0;
        p0_min  = steep_c ? lx0 : ly0;
        p1_maj  = steep_c ? ly1 : lx1;
        p1_min  = steep_c ? lx1 : ly1;
        swap_c  = p0_maj > p1_maj;
        s_maj   = swap_c ? p1_maj : p0_maj;
        s_min   = swap_c ? p1_min : p0_min;
        e_maj   = swap_c ? p0_maj : p1_maj;
        e_min   = swap_c ? p0_min : p1_min;
        dx_c    = e_maj - s_maj;
        dy_c    = (e_min >= s_min) ? e_min - s_min : s_min - e_min;
    end

    // A zero-slope line never steps its minor axis; only dx <= 1 would otherwise reach err >= 0.
    logic signed [EW-1:0] err_acc;
    logic                 step_minor;

    always_comb begin
        err_acc    = err + $signed({2'b00, dy});
        step_minor = (dy != '0) && !err_acc[EW-1];
    end

    logic visible;
`ifdef LINE_RASTER_CLIP_EN
    logic [W-1:0] px, py;
    always_comb begin
        px      = steep ? minor : major;
        py      = steep ? major : minor;
        visible = (int'(px) <= X_MAX) && (int'(py) <= Y_MAX);
    end
`else
    logic unused_limits;
    assign unused_limits = ^{X_MAX, Y_MAX};
    assign visible       = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every path assigns state_next a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (set) state_next = S_INIT;
            S_INIT:  state_next = S_DRAW;
            S_DRAW:  if (major == end_major) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lx0         <= '0;
            ly0         <= '0;
            lx1         <= '0;
            ly1         <= '0;
            major       <= '0;
            minor       <= '0;
            end_major   <= '0;
            dx          <= '0;
            dy          <= '0;
            err         <= '0;
            steep       <= 1'b0;
            ystep       <= 1'b0;
            x           <= '0;
            y           <= '0;
            color       <= 1'b0;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (set) begin
                        lx0   <= W'(x0);
                        ly0   <= W'(y0);
                        lx1   <= W'(x1);
                        ly1   <= W'(y1);
                        color <= color_in;
                        busy  <= 1'b1;
                    end
                end
                S_INIT: begin
                    steep     <= steep_c;
                    major     <= s_maj;
                    minor     <= s_min;
                    end_major <= e_maj;
                    dx        <= dx_c;
                    dy        <= dy_c;
                    ystep     <= s_min < e_min;
                    err       <= -$signed({3'b000, dx_c[W-1:1]});
                end
                S_DRAW: begin
                    x           <= steep ? minor[X_WIDTH-1:0] : major[X_WIDTH-1:0];
                    y           <= steep ? major[Y_WIDTH-1:0] : minor[Y_WIDTH-1:0];
                    pixel_valid <= visible;
                    major       <= major + W'(1);
                    if (step_minor) begin
                        minor <= ystep ? minor + W'(1) : minor - W'(1);
                        err   <= err_acc - $signed({2'b00, dx});
                    end else begin
                        err   <= err_acc;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// Directed, table-driven bench for line_raster; clip expectations follow LINE_RASTER_CLIP_EN.
`timescale 1ns/1ps
module tb_line_raster;

    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic [XW-1:0] x0, x1, x;
    logic [YW-1:0] y0, y1, y;
    logic          color_in, set, color, pixel_valid, busy, done;

    line_raster dut (
        .clk(clk), .reset(reset),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .color_in(color_in), .set(set),
        .x(x), .y(y), .color(color),
        .pixel_valid(pixel_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One directed line: endpoints, expected strobe count n, pixel cycles len,
    // and expected pixels either as a straight run (lin) or an explicit list.
    typedef struct {
        int   x0, y0, x1, y1;
        logic c;
        int   n, len;
        bit   lin;
        int   fx, fy, sx, sy;
        int   px[8];
        int   py[8];
    } vec_t;

    function automatic vec_t mk(int ax0, int ay0, int ax1, int ay1, logic c, int n, int len,
                                int fx, int fy, int sx, int sy);
        vec_t v;
        v.x0 = ax0; v.y0 = ay0; v.x1 = ax1; v.y1 = ay1; v.c = c;
        v.n = n; v.len = len; v.lin = 1'b1;
        v.fx = fx; v.fy = fy; v.sx = sx; v.sy = sy;
        v.px = '{0, 0, 0, 0, 0, 0, 0, 0};
        v.py = '{0, 0, 0, 0, 0, 0, 0, 0};
        return v;
    endfunction

    function automatic bit on_screen(int px, int py);
`ifdef LINE_RASTER_CLIP_EN
        return (px <= 639) && (py <= 479);
`else
        return (px >= 0) && (py >= 0);
`endif
    endfunction

    task automatic run_line(input vec_t v, input string tag);
        int ex_x, ex_y, strobes;
        bit exp_v;
        @(negedge clk);
        x0 = v.x0[XW-1:0]; y0 = v.y0[YW-1:0];
        x1 = v.x1[XW-1:0]; y1 = v.y1[YW-1:0];
        color_in = v.c; set = 1'b1;
        @(negedge clk);
        set = 1'b0;
        // Scramble the inputs to show the line uses only the latched copies.
        x0 = '1; y0 = '1; x1 = '0; y1 = '0; color_in = ~v.c;
        check({tag, " busy after set"}, busy, 1);
        check({tag, " no strobe after set"}, pixel_valid, 0);
        strobes = 0;
        for (int c = 1; c <= v.len + 3; c++) begin
            @(negedge clk);
            ex_x  = v.lin ? v.fx + (c - 2) * v.sx : v.px[(c - 2) & 7];
            ex_y  = v.lin ? v.fy + (c - 2) * v.sy : v.py[(c - 2) & 7];
            exp_v = (c >= 2) && (c <= v.len + 1) && on_screen(ex_x, ex_y);
            check({tag, " pixel_valid"}, pixel_valid, exp_v);
            if (exp_v && pixel_valid) begin
                check({tag, " x"}, x, ex_x);
                check({tag, " y"}, y, ex_y);
                check({tag, " color"}, color, v.c);
            end
            if (pixel_valid) strobes++;
            check({tag, " done"}, done, c == v.len + 2);
            check({tag, " busy"}, busy, c < v.len + 2);
        end
        check({tag, " strobe count"}, strobes, v.n);
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color_in = 1'b0; set = 1'b0;
        reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        check("reset x", x, 0);
        check("reset y", y, 0);
        check("reset color", color, 0);
        check("reset pixel_valid", pixel_valid, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        vecs.push_back(mk(0, 0, 639, 0, 1'b0, 640, 640, 0, 0, 1, 0));
        vecs.push_back(mk(5, 10, 5, 3, 1'b1, 8, 8, 5, 3, 0, 1));
        v = mk(0, 0, 4, 2, 1'b1, 5, 5, 0, 0, 0, 0);
        v.lin = 1'b0;
        v.px = '{0, 1, 2, 3, 4, 0, 0, 0};
        v.py = '{0, 1, 1, 2, 2, 0, 0, 0};
        vecs.push_back(v);
        v.x0 = 4; v.y0 = 2; v.x1 = 0; v.y1 = 0;
        vecs.push_back(v);
        vecs.push_back(mk(7, 7, 7, 7, 1'b1, 1, 1, 7, 7, 0, 0));
        vecs.push_back(mk(10, 20, 14, 16, 1'b0, 5, 5, 10, 20, 1, -1));
        vecs.push_back(mk(1, 0, 0, 0, 1'b1, 2, 2, 0, 0, 1, 0));
        v = mk(2, 0, 0, 5, 1'b1, 6, 6, 0, 0, 0, 0);
        v.lin = 1'b0;
        v.px = '{2, 1, 1, 1, 0, 0, 0, 0};
        v.py = '{0, 1, 2, 3, 4, 5, 0, 0};
        vecs.push_back(v);
        vecs.push_back(mk(0, 0, 0, 479, 1'b1, 480, 480, 0, 0, 0, 1));
`ifdef LINE_RASTER_CLIP_EN
        vecs.push_back(mk(630, 470, 645, 470, 1'b1, 10, 16, 630, 470, 1, 0));
`else
        vecs.push_back(mk(630, 470, 645, 470, 1'b1, 16, 16, 630, 470, 1, 0));
`endif

        foreach (vecs[i]) run_line(vecs[i], $sformatf("vec%0d", i));

        // Second set mid-line is ignored; reset at pixel 40 abandons the line with no done.
        begin : mid_line
            int  seen, dones;
            bit  pulsed;
            seen = 0; dones = 0; pulsed = 1'b0;
            @(negedge clk);
            x0 = 0; y0 = 0; x1 = 100; y1 = 50; color_in = 1'b1; set = 1'b1;
            @(negedge clk);
            set = 1'b0;
            for (int c = 1; c <= 200 && seen < 40; c++) begin
                @(negedge clk);
                set = 1'b0;
                if (done) dones++;
                if (pixel_valid) begin
                    check("midline x", x, seen);
                    check("midline y", y, (seen + 1) / 2);
                    seen++;
                    if (seen == 20 && !pulsed) begin
                        x0 = 9; y0 = 9; x1 = 9; y1 = 9; color_in = 1'b0; set = 1'b1;
                        pulsed = 1'b1;
                    end
                end
            end
            check("midline strobes before reset", seen, 40);
            check("midline busy before reset", busy, 1);
            reset = 1'b0;
            #1;
            check("midline reset x", x, 0);
            check("midline reset y", y, 0);
            check("midline reset color", color, 0);
            check("midline reset pixel_valid", pixel_valid, 0);
            check("midline reset busy", busy, 0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (done) dones++;
            end
            check("midline no done", dones, 0);
            reset = 1'b1;
        end

        // The block must be idle again: a fresh single-point line runs with normal timing.
        run_line(mk(7, 7, 7, 7, 1'b1, 1, 1, 7, 7, 0, 0), "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
